sd_dma_sram_wr: RTL and testbench

Write-side SRAM adapter directly downstream of the SD DMA engine. It consumes the engine's byte stream: a one-cycle next-address pulse, an active-low write strobe and an 8-bit data bus. It keeps the SRAM destination address counter, enforces an inclusive upper address limit, and converts each strobed byte into one arbitrated SRAM write cycle. It sits between the SD DMA engine and the memory arbiter in front of the external SRAM.

---
 rtl/sd_dma_sram_wr_if.sv | 25 ++
 rtl/sd_dma_sram_wr.sv | 154 +++++++++++++++
 tb/tb_sd_dma_sram_wr.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_dma_sram_wr_if.sv
// Byte-stream and SRAM write-port bundle between the SD DMA engine, the write adapter and the arbiter.
// The slave view belongs to the adapter; the master view belongs to the engine and arbiter side.
interface sd_dma_sram_wr_if #(
  parameter int ADDR_W = 24
);
  logic              DMA_STATUS;
  logic              DMA_WE_N;
  logic              DMA_NEXTADDR;
  logic [7:0]        DMA_DATA;
  logic              SRAM_REQ;
  logic              SRAM_GNT;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [7:0]        SRAM_DATA;
  logic              SRAM_WE_N;

  modport slave (
    input  DMA_STATUS, DMA_WE_N, DMA_NEXTADDR, DMA_DATA, SRAM_GNT,
    output SRAM_REQ, SRAM_ADDR, SRAM_DATA, SRAM_WE_N
  );

  modport master (
    output DMA_STATUS, DMA_WE_N, DMA_NEXTADDR, DMA_DATA, SRAM_GNT,
    input  SRAM_REQ, SRAM_ADDR, SRAM_DATA, SRAM_WE_N
  );
endinterface

// File: rtl/sd_dma_sram_wr.sv
// SD DMA write-side SRAM adapter: captures strobed bytes, tracks the destination address
// against an inclusive limit and turns each accepted byte into one arbitrated SRAM write.
module sd_dma_sram_wr #(
  parameter int ADDR_W  = 24,
  parameter int WE_LEN  = 3,
  parameter int CAP_DLY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic              BASE_LOAD,
  input  logic [ADDR_W-1:0] LIMIT_ADDR,
  sd_dma_sram_wr_if.slave   bus,
  output logic              BUSY,
  output logic [15:0]       BYTE_COUNT,
  output logic              OVERFLOW,
  output logic              OVERRUN
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WRITE   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t            state_q;
  logic              we_q;
  logic [2:0]        low_cnt_q;
  logic [2:0]        wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [7:0]        cap_data_q;
  logic              req_q;
  logic              sram_we_n_q;
  logic              busy_q;
  logic [15:0]       cnt_q;
  logic              ovf_q;
  logic              ovr_q;
  logic              cap_ev;
  logic              over_lim;

  // The counter stops at CAP_DLY, so a single long low run can only produce one capture.
  assign cap_ev   = !we_q && bus.DMA_STATUS && (low_cnt_q == 3'(CAP_DLY - 1));
  assign over_lim = addr_q > LIMIT_ADDR;

  // Next destination address: a base load overrides a coincident increment.
  always_comb begin
    addr_d = addr_q;
    if (BASE_LOAD) begin
      addr_d = BASE_ADDR;
    end else if (bus.DMA_NEXTADDR) begin
      addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      addr_d = addr_q;
    end
  end

  // Strobe qualification, address counter, write FSM and status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      we_q        <= 1'b1;
      low_cnt_q   <= 3'd0;
      wcnt_q      <= 3'd0;
      addr_q      <= '0;
      cap_addr_q  <= '0;
      cap_data_q  <= 8'h00;
      req_q       <= 1'b0;
      sram_we_n_q <= 1'b1;
      busy_q      <= 1'b0;
      cnt_q       <= 16'h0000;
      ovf_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      we_q   <= bus.DMA_WE_N;
      addr_q <= addr_d;

      if (we_q) begin
        low_cnt_q <= 3'd0;
      end else if (bus.DMA_STATUS && (low_cnt_q < 3'(CAP_DLY))) begin
        low_cnt_q <= low_cnt_q + 3'd1;
      end

      case (state_q)
        IDLE: begin
          if (cap_ev) begin
            cap_addr_q <= addr_q;
            cap_data_q <= bus.DMA_DATA;
            if (over_lim) begin
              ovf_q <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.SRAM_GNT) begin
            state_q     <= WRITE;
            sram_we_n_q <= 1'b0;
            wcnt_q      <= 3'd0;
            if (cnt_q != 16'hFFFF) begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        WRITE: begin
          if (wcnt_q == 3'(WE_LEN - 1)) begin
            state_q     <= RECOVER;
            sram_we_n_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        RECOVER: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          req_q       <= 1'b0;
          sram_we_n_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase

      // A strobe arriving while a write is in flight is dropped and flagged.
      if (cap_ev && (state_q != IDLE)) begin
        ovr_q <= 1'b1;
      end

      // Placed last so a base load beats any same-cycle count or flag update.
      if (BASE_LOAD) begin
        cnt_q <= 16'h0000;
        ovf_q <= 1'b0;
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.SRAM_REQ  = req_q;
  assign bus.SRAM_ADDR = cap_addr_q;
  assign bus.SRAM_DATA = cap_data_q;
  assign bus.SRAM_WE_N = sram_we_n_q;
  assign BUSY          = busy_q;
  assign BYTE_COUNT    = cnt_q;
  assign OVERFLOW      = ovf_q;
  assign OVERRUN       = ovr_q;

endmodule

// File: tb/tb_sd_dma_sram_wr.sv
// Self-checking bench for sd_dma_sram_wr: a byte-level model predicts the SRAM writes and
// flags, and a bus monitor records every observed SRAM write cycle for comparison.
module tb_sd_dma_sram_wr;
  localparam int ADDR_W = 24;
  localparam int WE_LEN = 3;

  typedef struct { logic [23:0] a; logic [7:0] d; } exp_t;
  typedef struct { logic [23:0] a; logic [7:0] d; int len; bit stable; } obs_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [23:0] BASE_ADDR = 24'h0;
  logic        BASE_LOAD = 1'b0;
  logic [23:0] LIMIT_ADDR = 24'hFFFFFF;
  logic        BUSY;
  logic [15:0] BYTE_COUNT;
  logic        OVERFLOW, OVERRUN;

  sd_dma_sram_wr_if #(.ADDR_W(ADDR_W)) bus ();

  sd_dma_sram_wr #(.ADDR_W(ADDR_W), .WE_LEN(WE_LEN), .CAP_DLY(2)) dut (
    .CLK(CLK), .RST(RST), .BASE_ADDR(BASE_ADDR), .BASE_LOAD(BASE_LOAD),
    .LIMIT_ADDR(LIMIT_ADDR), .bus(bus), .BUSY(BUSY), .BYTE_COUNT(BYTE_COUNT),
    .OVERFLOW(OVERFLOW), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [23:0] m_addr = 24'h0;
  logic [15:0] m_cnt = 16'h0;
  bit          m_ovf = 1'b0, m_ovr = 1'b0;
  exp_t        exp_q[$];
  obs_t        obs_q[$];

  // Monitor state
  bit          mon_in_write = 1'b0, mon_post = 1'b0;
  logic        prev_we = 1'b1, prev_req = 1'b0;
  logic [23:0] prev_addr = 24'h0;
  logic [7:0]  prev_data = 8'h0;
  obs_t        cur;
  int          req_rises = 0;

  // Records each SRAM write cycle and whether address/data stayed stable around it.
  always @(negedge CLK) begin
    if (RST) begin
      mon_in_write = 1'b0;
      mon_post     = 1'b0;
    end else begin
      if (mon_post) begin
        if (bus.SRAM_ADDR !== cur.a || bus.SRAM_DATA !== cur.d) cur.stable = 1'b0;
        obs_q.push_back(cur);
        mon_post = 1'b0;
      end
      if (!mon_in_write && prev_we === 1'b1 && bus.SRAM_WE_N === 1'b0) begin
        mon_in_write = 1'b1;
        cur.a = bus.SRAM_ADDR;
        cur.d = bus.SRAM_DATA;
        cur.len = 1;
        cur.stable = (prev_addr === bus.SRAM_ADDR) && (prev_data === bus.SRAM_DATA);
      end else if (mon_in_write) begin
        if (bus.SRAM_ADDR !== cur.a || bus.SRAM_DATA !== cur.d) cur.stable = 1'b0;
        if (bus.SRAM_WE_N === 1'b0) begin
          cur.len++;
        end else begin
          mon_in_write = 1'b0;
          mon_post = 1'b1;
        end
      end
      if (prev_req === 1'b0 && bus.SRAM_REQ === 1'b1) req_rises++;
    end
    prev_we   = bus.SRAM_WE_N;
    prev_req  = bus.SRAM_REQ;
    prev_addr = bus.SRAM_ADDR;
    prev_data = bus.SRAM_DATA;
  end

  task automatic model_byte(input logic [7:0] d);
    exp_t e;
    if (m_addr <= LIMIT_ADDR) begin
      e.a = m_addr;
      e.d = d;
      exp_q.push_back(e);
      if (m_cnt != 16'hFFFF) m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_next();
    m_addr = m_addr + 24'd1;
  endtask

  task automatic load_base(input logic [23:0] b, input logic with_next);
    @(negedge CLK);
    BASE_ADDR = b;
    BASE_LOAD = 1'b1;
    bus.DMA_NEXTADDR = with_next;
    @(negedge CLK);
    BASE_LOAD = 1'b0;
    bus.DMA_NEXTADDR = 1'b0;
    m_addr = b; m_cnt = 16'h0; m_ovf = 1'b0; m_ovr = 1'b0;
    exp_q.delete(); obs_q.delete(); req_rises = 0;
  endtask

  // One engine byte: strobe low 4 cycles; na_mode 0 = next-address after, 1 = at capture, 2 = none.
  task automatic send_byte(input logic [7:0] d, input int na_mode);
    @(negedge CLK); bus.DMA_DATA = d; bus.DMA_WE_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK); if (na_mode == 1) bus.DMA_NEXTADDR = 1'b1;
    @(negedge CLK); bus.DMA_NEXTADDR = 1'b0;
    @(negedge CLK); bus.DMA_WE_N = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK); if (na_mode == 0) bus.DMA_NEXTADDR = 1'b1;
    @(negedge CLK); bus.DMA_NEXTADDR = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    int quiet = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (!BUSY && !mon_in_write && !mon_post) quiet++; else quiet = 0;
      if (quiet >= 2) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({bus.SRAM_REQ, bus.SRAM_WE_N, BUSY, OVERFLOW, OVERRUN} !== 5'b01000) begin
      n_fail++; $display("FAIL reset_ctrl got req/we_n/busy/ovf/ovr=%b want 01000",
                         {bus.SRAM_REQ, bus.SRAM_WE_N, BUSY, OVERFLOW, OVERRUN});
    end
    n_checks++;
    if (bus.SRAM_ADDR !== 24'h0 || bus.SRAM_DATA !== 8'h0 || BYTE_COUNT !== 16'h0) begin
      n_fail++; $display("FAIL reset_data got addr=%h data=%h cnt=%h want 0/0/0",
                         bus.SRAM_ADDR, bus.SRAM_DATA, BYTE_COUNT);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_address_load();
    logic [7:0] pat [4] = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
    bit to;
    LIMIT_ADDR = 24'hFFFFFF;
    load_base(24'h001000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(pat[i], 0); model_byte(pat[i]); model_next();
    end
    wait_idle(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL load_idle timeout got busy=%b want 0", BUSY); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL load_nwrites got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].a !== exp_q[i].a || obs_q[i].d !== exp_q[i].d || obs_q[i].len != WE_LEN || !obs_q[i].stable) begin
        n_fail++; $display("FAIL load_write%0d got a=%h d=%h len=%0d stable=%0d want a=%h d=%h len=%0d stable=1",
                           i, obs_q[i].a, obs_q[i].d, obs_q[i].len, obs_q[i].stable, exp_q[i].a, exp_q[i].d, WE_LEN);
      end
    end
    n_checks++;
    if (BYTE_COUNT !== m_cnt) begin n_fail++; $display("FAIL load_count got %0d want %0d", BYTE_COUNT, m_cnt); end
  endtask

  task automatic test_limit();
    bit to;
    LIMIT_ADDR = 24'h001001;
    load_base(24'h001000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d = 8'($urandom);
      send_byte(d, 0); model_byte(d); model_next();
      if (i == 1 || i == 2) begin
        n_checks++;
        if (OVERFLOW !== m_ovf) begin
          n_fail++; $display("FAIL limit_ovf_byte%0d got %b want %b", i + 1, OVERFLOW, m_ovf);
        end
      end
    end
    wait_idle(to);
    n_checks++;
    if (to || req_rises != exp_q.size() || obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL limit_writes got req=%0d writes=%0d timeout=%0d want %0d/%0d/0",
                         req_rises, obs_q.size(), to, exp_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].a !== exp_q[i].a || obs_q[i].d !== exp_q[i].d) begin
        n_fail++; $display("FAIL limit_write%0d got a=%h d=%h want a=%h d=%h",
                           i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    n_checks++;
    if (BYTE_COUNT !== m_cnt || OVERFLOW !== 1'b1 || OVERRUN !== 1'b0) begin
      n_fail++; $display("FAIL limit_status got cnt=%0d ovf=%b ovr=%b want %0d/1/0", BYTE_COUNT, OVERFLOW, OVERRUN, m_cnt);
    end
  endtask

  task automatic test_grant_stall();
    logic [7:0] d1 = 8'($urandom), d2 = 8'($urandom);
    bit to;
    LIMIT_ADDR = 24'hFFFFFF;
    load_base(24'h002000, 1'b0);
    bus.SRAM_GNT = 1'b0;
    send_byte(d1, 0); model_byte(d1); model_next();
    n_checks++;
    if (bus.SRAM_REQ !== 1'b1 || bus.SRAM_WE_N !== 1'b1 || bus.SRAM_ADDR !== 24'h002000 || bus.SRAM_DATA !== d1) begin
      n_fail++; $display("FAIL stall_hold1 got req=%b we_n=%b a=%h d=%h want 1/1/002000/%h",
                         bus.SRAM_REQ, bus.SRAM_WE_N, bus.SRAM_ADDR, bus.SRAM_DATA, d1);
    end
    send_byte(d2, 0); m_ovr = 1'b1; model_next();
    n_checks++;
    if (bus.SRAM_REQ !== 1'b1 || bus.SRAM_ADDR !== 24'h002000 || bus.SRAM_DATA !== d1 || OVERRUN !== m_ovr) begin
      n_fail++; $display("FAIL stall_hold2 got req=%b a=%h d=%h ovr=%b want 1/002000/%h/1",
                         bus.SRAM_REQ, bus.SRAM_ADDR, bus.SRAM_DATA, OVERRUN, d1);
    end
    bus.SRAM_GNT = 1'b1;
    wait_idle(to);
    n_checks++;
    if (to || obs_q.size() != 1) begin
      n_fail++; $display("FAIL stall_nwrites got %0d timeout=%0d want 1/0", obs_q.size(), to);
    end else if (obs_q[0].a !== exp_q[0].a || obs_q[0].d !== exp_q[0].d || !obs_q[0].stable) begin
      n_fail++; $display("FAIL stall_write got a=%h d=%h stable=%0d want a=%h d=%h stable=1",
                         obs_q[0].a, obs_q[0].d, obs_q[0].stable, exp_q[0].a, exp_q[0].d);
    end
    n_checks++;
    if (BYTE_COUNT !== m_cnt || OVERRUN !== 1'b1 || OVERFLOW !== 1'b0) begin
      n_fail++; $display("FAIL stall_status got cnt=%0d ovr=%b ovf=%b want %0d/1/0", BYTE_COUNT, OVERRUN, OVERFLOW, m_cnt);
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen = 1'b0;
    @(negedge CLK); bus.DMA_DATA = 8'h3C; bus.DMA_WE_N = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (bus.SRAM_WE_N === 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rstmid_start got no write want SRAM_WE_N low"); end
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if (bus.SRAM_WE_N !== 1'b1 || bus.SRAM_REQ !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async got we_n=%b req=%b want 1/0", bus.SRAM_WE_N, bus.SRAM_REQ);
    end
    n_checks++;
    if (BYTE_COUNT !== 16'h0 || OVERFLOW !== 1'b0 || OVERRUN !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_status got cnt=%0d ovf=%b ovr=%b busy=%b want 0/0/0/0",
                         BYTE_COUNT, OVERFLOW, OVERRUN, BUSY);
    end
    bus.DMA_WE_N = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    m_addr = 24'h0; m_cnt = 16'h0; m_ovf = 1'b0; m_ovr = 1'b0;
    exp_q.delete(); obs_q.delete();
    @(negedge CLK);
  endtask

  task automatic test_wrap();
    logic [7:0] d1 = 8'($urandom), d2 = 8'($urandom), d3 = 8'($urandom);
    logic [23:0] b = 24'($urandom);
    bit to;
    LIMIT_ADDR = 24'hFFFFFF;
    load_base(24'hFFFFFF, 1'b0);
    send_byte(d1, 1); model_byte(d1); model_next();
    send_byte(d2, 0); model_byte(d2); model_next();
    wait_idle(to);
    n_checks++;
    if (to || obs_q.size() != 2) begin
      n_fail++; $display("FAIL wrap_nwrites got %0d timeout=%0d want 2/0", obs_q.size(), to);
    end else begin
      n_checks++;
      if (obs_q[0].a !== 24'hFFFFFF || obs_q[1].a !== 24'h000000 || obs_q[0].d !== d1 || obs_q[1].d !== d2) begin
        n_fail++; $display("FAIL wrap_addr got %h/%h d=%h/%h want FFFFFF/000000 d=%h/%h",
                           obs_q[0].a, obs_q[1].a, obs_q[0].d, obs_q[1].d, d1, d2);
      end
    end
    load_base(b, 1'b1);
    send_byte(d3, 2); model_byte(d3);
    wait_idle(to);
    n_checks++;
    if (to || obs_q.size() != 1 || obs_q[0].a !== b || obs_q[0].d !== d3) begin
      n_fail++; $display("FAIL load_vs_next got n=%0d a=%h want n=1 a=%h", obs_q.size(),
                         (obs_q.size() > 0) ? obs_q[0].a : 24'hx, b);
    end
  endtask

  task automatic test_random();
    bit to;
    for (int it = 0; it < 4; it++) begin
      logic [23:0] b = 24'($urandom);
      LIMIT_ADDR = b + 24'($urandom_range(0, 5));
      load_base(b, 1'b0);
      for (int k = 0; k < 6; k++) begin
        logic [7:0] d = 8'($urandom);
        int mode = $urandom_range(0, 2);
        send_byte(d, mode);
        model_byte(d);
        if (mode != 2) model_next();
      end
      wait_idle(to);
      n_checks++;
      if (to || obs_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_nwrites got %0d timeout=%0d want %0d/0", it, obs_q.size(), to, exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i].a !== exp_q[i].a || obs_q[i].d !== exp_q[i].d || obs_q[i].len != WE_LEN) begin
          n_fail++; $display("FAIL rand%0d_write%0d got a=%h d=%h len=%0d want a=%h d=%h len=%0d",
                             it, i, obs_q[i].a, obs_q[i].d, obs_q[i].len, exp_q[i].a, exp_q[i].d, WE_LEN);
        end
      end
      n_checks++;
      if (BYTE_COUNT !== m_cnt || OVERFLOW !== m_ovf || OVERRUN !== m_ovr) begin
        n_fail++; $display("FAIL rand%0d_status got cnt=%0d ovf=%b ovr=%b want %0d/%b/%b",
                           it, BYTE_COUNT, OVERFLOW, OVERRUN, m_cnt, m_ovf, m_ovr);
      end
    end
  endtask

  initial begin
    bus.DMA_STATUS = 1'b1;
    bus.DMA_WE_N = 1'b1;
    bus.DMA_NEXTADDR = 1'b0;
    bus.DMA_DATA = 8'h00;
    bus.SRAM_GNT = 1'b1;
    test_reset();
    test_address_load();
    test_limit();
    test_grant_stall();
    test_reset_mid_write();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got no finish want finish before 1ms");
    $fatal(1, "timeout");
  end
endmodule
